// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI master among NUM_REQ requesters.
// Optional build macro SPI_ARB_PRIO0_EN: requester 0 gets fixed top priority,
// round-robin among requesters 1..NUM_REQ-1 otherwise.
module spi_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_tx,
  input  logic [2*NUM_REQ-1:0]    req_ss,
  input  logic [4*NUM_REQ-1:0]    req_len,
  input  logic [NUM_REQ-1:0]      req_lsb,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ack,
  output logic [15:0]             rsp_data,
  output logic                    spi_tx_start,
  output logic                    spi_rx_start,
  output logic [3:0]              spi_word_length,
  output logic [1:0]              spi_ss_select,
  output logic                    spi_lsb_first,
  output logic [15:0]             spi_tx_data,
  input  logic                    spi_tx_ready,
  input  logic                    spi_rx_ready,
  input  logic                    spi_rx_data_ready,
  input  logic [15:0]             spi_rx_data,
  output logic                    spi_rx_ack
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned SS_W   = 2;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK, S_RESP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_nxt;
  logic                r_tx, w_tx_nxt;
  logic [NUM_REQ-1:0]  r_req_ready, w_req_ready_nxt;
  logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                r_tx_start, w_tx_start_nxt;
  logic                r_rx_start, w_rx_start_nxt;
  logic                r_rx_ack, w_rx_ack_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [SS_W-1:0]     r_ss, w_ss_nxt;
  logic                r_lsb, w_lsb_nxt;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_nxt;

  logic                w_win_found;
  logic [IDX_W-1:0]    w_win_idx;
  logic [IDX_W-1:0]    w_scan;
  logic [IDX_W-1:0]    w_base;

  assign req_ready       = r_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign spi_tx_start    = r_tx_start;
  assign spi_rx_start    = r_rx_start;
  assign spi_rx_ack      = r_rx_ack;
  assign spi_word_length = r_len;
  assign spi_ss_select   = r_ss;
  assign spi_lsb_first   = r_lsb;
  assign spi_tx_data     = r_tx_data;

  // Winner selection: first valid requester scanning upward from rr_ptr
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan      = '0;
    w_base      = '0;
`ifdef SPI_ARB_PRIO0_EN
    w_base = (r_rr_ptr == '0) ? IDX_W'(1) : r_rr_ptr;
    if (req_valid[0]) begin
      w_win_found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
        w_scan = IDX_W'(1 + ((32'(w_base) - 1 + k) % (NUM_REQ - 1)));
        if (!w_win_found && req_valid[w_scan]) begin
          w_win_found = 1'b1;
          w_win_idx   = w_scan;
        end
      end
    end
`else
    w_base = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = IDX_W'((32'(w_base) + k) % NUM_REQ);
      if (!w_win_found && req_valid[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
    end
`endif
  end

  // Next-state and next-output logic; all outputs are registered from these
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_rr_nxt        = r_rr_ptr;
    w_tx_nxt        = r_tx;
    w_req_ready_nxt = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_tx_start_nxt  = 1'b0;
    w_rx_start_nxt  = 1'b0;
    w_rx_ack_nxt    = 1'b0;
    w_len_nxt       = r_len;
    w_ss_nxt        = r_ss;
    w_lsb_nxt       = r_lsb;
    w_tx_data_nxt   = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (w_win_found && spi_tx_ready && spi_rx_ready) begin
          w_gnt_nxt                  = w_win_idx;
          w_tx_nxt                   = req_tx[w_win_idx];
          w_len_nxt                  = req_len[LEN_W*w_win_idx +: LEN_W];
          w_ss_nxt                   = req_ss[SS_W*w_win_idx +: SS_W];
          w_lsb_nxt                  = req_lsb[w_win_idx];
          w_tx_data_nxt              = req_data[DATA_W*w_win_idx +: DATA_W];
          w_req_ready_nxt[w_win_idx] = 1'b1;
          w_tx_start_nxt             = req_tx[w_win_idx];
          w_rx_start_nxt             = !req_tx[w_win_idx];
          w_state_nxt                = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef SPI_ARB_PRIO0_EN
        if (r_gnt != '0) begin
          w_rr_nxt = (32'(r_gnt) == NUM_REQ - 1) ? IDX_W'(1) : r_gnt + IDX_W'(1);
        end
`else
        w_rr_nxt = (32'(r_gnt) == NUM_REQ - 1) ? '0 : r_gnt + IDX_W'(1);
`endif
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!spi_tx_ready) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (r_tx) begin
          if (spi_tx_ready) begin
            w_rsp_data_nxt         = '0;
            w_rsp_valid_nxt[r_gnt] = 1'b1;
            w_state_nxt            = S_RESP;
          end
        end else if (spi_rx_data_ready) begin
          // Capture before acking: the master clears its buffer afterwards
          w_rsp_data_nxt = spi_rx_data;
          w_rx_ack_nxt   = 1'b1;
          w_state_nxt    = S_ACK;
        end
      end
      S_ACK: begin
        w_rsp_valid_nxt[r_gnt] = 1'b1;
        w_state_nxt            = S_RESP;
      end
      S_RESP: begin
        if (rsp_ack[r_gnt]) w_state_nxt = S_IDLE;
        else                w_rsp_valid_nxt[r_gnt] = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_tx        <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_tx_start  <= 1'b0;
      r_rx_start  <= 1'b0;
      r_rx_ack    <= 1'b0;
      r_len       <= '0;
      r_ss        <= '0;
      r_lsb       <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_tx        <= w_tx_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_rx_start  <= w_rx_start_nxt;
      r_rx_ack    <= w_rx_ack_nxt;
      r_len       <= w_len_nxt;
      r_ss        <= w_ss_nxt;
      r_lsb       <= w_lsb_nxt;
      r_tx_data   <= w_tx_data_nxt;
    end
  end

endmodule
